// File: rtl/cga_vram_writer.sv
// cga_vram_writer: CPU-side VRAM port for the CGA adapter.
//
// ISA memory cycles that decode into the B8000-BFFFF window are turned into
// VRAM accesses. The accesses happen only in the sequencer's isa_op_enable slots,
// so display fetches are never disturbed. Writes are posted through a small FIFO.
// A read first waits for that FIFO to drain, then waits for a free slot, so a
// write followed by a read of the same byte returns the new data. Wait states
// are inserted on bus_rdy while a write is stalled on a full FIFO and while a
// read is outstanding.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   bus_a/bus_d           ISA address and write data
//   bus_memr_l/memw_l     ISA memory strobes (active low, asynchronous to clk)
//   bus_aen               DMA address enable; high blocks decode
//   bus_out/bus_dir       read data to ISA and its drive enable
//   bus_rdy               ISA ready; low inserts wait states
//   isa_op_enable         one-clk slot pulse from the sequencer
//   ram_a/ram_d_out       VRAM address and write data (valid while ram_cycle)
//   ram_we_l              VRAM write enable, active low
//   ram_d                 VRAM read data, valid 1 clk after the address
//   ram_cycle             this block owns the VRAM bus in this clk
//   fifo_level            posted-write count, 0..FIFO_DEPTH
//
// FIFO_DEPTH must be a power of 2 and at least 2.
//
// Optional build: define CGA_VRAM_SNOW_EN to add the display_enable input and the
// snow_strobe/snow_data outputs. Each VRAM write that is issued while
// display_enable is high pulses snow_strobe for 1 clk. snow_data carries the
// written byte, and the pixel pipeline uses it to reproduce the CGA snow artefact.

module cga_vram_writer #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter logic [3:0]  RAM_PAGE         = 4'b0001,
  parameter int          FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [19:0]                 bus_a,
  input  logic                        bus_memr_l,
  input  logic                        bus_memw_l,
  input  logic                        bus_aen,
  input  logic [7:0]                  bus_d,
  output logic [7:0]                  bus_out,
  output logic                        bus_dir,
  output logic                        bus_rdy,
  input  logic                        isa_op_enable,
  output logic [18:0]                 ram_a,
  input  logic [7:0]                  ram_d,
  output logic [7:0]                  ram_d_out,
  output logic                        ram_we_l,
  output logic                        ram_cycle,
`ifdef CGA_VRAM_SNOW_EN
  input  logic                        display_enable,
  output logic                        snow_strobe,
  output logic [7:0]                  snow_data,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, WR_STALL, RD_WAIT, RD_ISSUE, RD_DONE} state_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } entry_t;

  state_t          state_q, state_d;
  entry_t          hold_q, hold_d;      // stalled write, or the offset of a pending read
  logic            rdy_q, rdy_d;
  logic [7:0]      bus_out_q, bus_out_d;
  logic [18:0]     ram_a_q;
  logic [7:0]      ram_d_out_q;

  // s1/s2 synchronise the strobes. s3 is the previous synced value and is
  // used only for edge detection.
  logic            memr_s1_q, memr_s2_q, memr_s3_q;
  logic            memw_s1_q, memw_s2_q, memw_s3_q;

  entry_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            fifo_empty, fifo_full;
  logic            push, pop, rd_slot;
  entry_t          push_entry, head;

  logic            mem_cs, wr_start, rd_start;

  assign mem_cs     = (bus_a[19:15] == FRAMEBUFFER_ADDR[19:15]) & ~bus_aen;
  assign wr_start   = memw_s3_q & ~memw_s2_q & mem_cs;
  // A write edge in the same clk wins; the read is ignored.
  assign rd_start   = memr_s3_q & ~memr_s2_q & mem_cs & ~wr_start;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr_q];

  // Slot arbitration: posted writes first, then a waiting read.
  assign pop        = isa_op_enable & ~fifo_empty;
  assign rd_slot    = isa_op_enable & fifo_empty & (state_q == RD_WAIT);

  // NOTE: always_comb gives every output a default before the case statement, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rdy_d      = rdy_q;
    bus_out_d  = bus_out_q;
    push       = 1'b0;
    push_entry = '{addr: bus_a[13:0], data: bus_d};

    unique case (state_q)
      IDLE: begin
        if (wr_start) begin
          if (!fifo_full) begin
            push = 1'b1;
          end else begin
            hold_d  = '{addr: bus_a[13:0], data: bus_d};
            rdy_d   = 1'b0;
            state_d = WR_STALL;
          end
        end else if (rd_start) begin
          hold_d  = '{addr: bus_a[13:0], data: 8'h00};
          rdy_d   = 1'b0;
          state_d = RD_WAIT;
        end
      end
      WR_STALL: begin
        // The FIFO is full, so the next slot always pops. The stalled entry takes
        // the freed place in that clk, and the level stays the same.
        if (pop) begin
          push       = 1'b1;
          push_entry = hold_q;
          rdy_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      RD_WAIT: begin
        if (rd_slot) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        // The address went out in the preceding slot clk, so ram_d is valid now.
        bus_out_d = ram_d;
        rdy_d     = 1'b1;
        state_d   = RD_DONE;
      end
      RD_DONE: begin
        if (memr_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The VRAM bus is driven only in slot clks. Otherwise the address and data
  // hold their last values.
  always_comb begin
    ram_cycle = pop | rd_slot;
    ram_we_l  = ~pop;
    if (pop)          ram_a = {RAM_PAGE, 1'b0, head.addr};
    else if (rd_slot) ram_a = {RAM_PAGE, 1'b0, hold_q.addr};
    else              ram_a = ram_a_q;
    ram_d_out = pop ? head.data : ram_d_out_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rdy_q       <= 1'b1;
      bus_out_q   <= 8'h00;
      ram_a_q     <= '0;
      ram_d_out_q <= 8'h00;
      memr_s1_q   <= 1'b1;
      memr_s2_q   <= 1'b1;
      memr_s3_q   <= 1'b1;
      memw_s1_q   <= 1'b1;
      memw_s2_q   <= 1'b1;
      memw_s3_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      rdy_q       <= rdy_d;
      bus_out_q   <= bus_out_d;
      ram_a_q     <= ram_a;
      ram_d_out_q <= ram_d_out;
      memr_s1_q   <= bus_memr_l;
      memr_s2_q   <= memr_s1_q;
      memr_s3_q   <= memr_s2_q;
      memw_s1_q   <= bus_memw_l;
      memw_s2_q   <= memw_s1_q;
      memw_s3_q   <= memw_s2_q;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
    end
  end

  // NOTE: the FIFO storage has no reset, because the pointers and the count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign bus_rdy    = rdy_q;
  assign bus_out    = bus_out_q;
  assign bus_dir    = mem_cs & ~bus_memr_l;
  assign fifo_level = count_q;

`ifdef CGA_VRAM_SNOW_EN
  logic       snow_strobe_q;
  logic [7:0] snow_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snow_strobe_q <= 1'b0;
      snow_data_q   <= 8'h00;
    end else begin
      snow_strobe_q <= pop & display_enable;
      if (pop) snow_data_q <= head.data;
    end
  end

  assign snow_strobe = snow_strobe_q;
  assign snow_data   = snow_data_q;
`endif

endmodule
